ahb_sram_slave: RTL and testbench

//  AHB-Lite slave (responder) bridging the CPU-initiated system bus to a single-port, synchronous-read

---
 rtl/ahb_sram_slave_pkg.sv | 26 ++
 rtl/ahb_byte_strobe.sv | 29 ++
 rtl/ahb_sram_slave.sv | 109 ++++++++++
 tb/tb_ahb_sram_slave.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
// Pure definitions: no latency and no backpressure of its own.
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps transfer size and low address bits to SRAM byte-lane strobes and flags misalignment.
// Purely combinational (zero latency); no backpressure.
module ahb_byte_strobe
  import ahb_sram_slave_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       illegal
);

  always_comb begin
    strb    = 4'b0000;
    illegal = 1'b0;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb    = 4'b0011 << {addr_lo[1], 1'b0};
        illegal = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb    = 4'b1111;
        illegal = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a single-port synchronous-read SRAM; zero-wait reads and writes.
// Backpressure: one wait state when a read address phase overlaps a write data phase; errors take two cycles.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP,
  output logic          SRAMCS,
  output logic [3:0]    SRAMWEN,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  input  logic [31:0]   SRAMRDATA
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [3:0]    strb_q;
  logic [3:0]    strb;
  logic          illegal;
  logic          acc;
  logic          acc_ok;
  logic          rd_now;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

  ahb_byte_strobe u_strobe (
    .size    (HSIZE),
    .addr_lo (HADDR[1:0]),
    .strb    (strb),
    .illegal (illegal)
  );

  assign acc       = HSEL & HTRANS[1] & HREADY;
  assign HREADYOUT = (state != ST_RD_WAIT) && (state != ST_ERR1);
  assign acc_ok    = acc & HREADYOUT & ~illegal;
  // While a write data phase owns the SRAM port, a new read has to wait a cycle.
  assign rd_now    = acc_ok & ~HWRITE & (state != ST_WR);
  assign HRDATA    = SRAMRDATA;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (HREADYOUT) begin
      if (!acc)                 state_nxt = ST_IDLE;
      else if (illegal)         state_nxt = ST_ERR1;
      else if (HWRITE)          state_nxt = ST_WR;
      else if (state == ST_WR)  state_nxt = ST_RD_WAIT;
      else                      state_nxt = ST_RD;
    end else if (state == ST_RD_WAIT) begin
      state_nxt = ST_RD;
    end else if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      strb_q <= '0;
    end else if (acc_ok) begin
      addr_q <= HADDR[AW+1:2];
      strb_q <= strb;
    end
  end

  always_comb begin
    HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = addr_q;
    SRAMWDATA = HWDATA;
    if (state == ST_WR) begin
      SRAMCS  = 1'b1;
      SRAMWEN = strb_q;
    end else if (state == ST_RD_WAIT) begin
      SRAMCS  = 1'b1;
    end else if (rd_now) begin
      SRAMCS   = 1'b1;
      SRAMADDR = HADDR[AW+1:2];
    end
    // Keep the SRAM quiet for the whole reset assertion, including any address phase on the bus.
    if (!HRESETn) begin
      SRAMCS  = 1'b0;
      SRAMWEN = 4'b0000;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave with a behavioural synchronous-read SRAM.
module tb_ahb_sram_slave;
  import ahb_sram_slave_pkg::*;

  localparam int AW = 15;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic          SRAMCS;
  logic [3:0]    SRAMWEN;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [31:0]   SRAMRDATA;

  int vectors = 0;
  int errs    = 0;

  bit   [31:0] mem [0:(1<<AW)-1];
  logic [31:0] vals [0:3];

  ahb_sram_slave #(.AW(AW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .SRAMCS    (SRAMCS),
    .SRAMWEN   (SRAMWEN),
    .SRAMADDR  (SRAMADDR),
    .SRAMWDATA (SRAMWDATA),
    .SRAMRDATA (SRAMRDATA)
  );

  always #5 HCLK = ~HCLK;

  // Single slave on the bus, so the bus ready is this slave's ready.
  assign HREADY = HREADYOUT;

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      for (int i = 0; i < 4; i++)
        if (SRAMWEN[i]) mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
      SRAMRDATA <= mem[SRAMADDR];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ap(input logic sel, input logic [1:0] trans, input logic wr,
                    input logic [2:0] size, input logic [31:0] addr);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
  endtask

  task automatic idle_ap();
    ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
  endtask

  initial begin
    vals[0] = 32'h1111_0000;
    vals[1] = 32'h2222_0001;
    vals[2] = 32'h3333_0002;
    vals[3] = 32'h4444_0003;

    HRESETn = 1'b0;
    HWDATA  = 32'h0;
    idle_ap();
    #12;
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    #1;
    chk("rst_rdy",  HREADYOUT, 1'b1);
    chk("rst_resp", HRESP,     1'b0);
    chk("rst_cs",   SRAMCS,    1'b0);
    chk("rst_wen",  SRAMWEN,   4'h0);
    HRESETn = 1'b1;
    idle_ap();
    tick();

    // Word write then back-to-back read of the same address.
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    tick();
    HWDATA = 32'hDEAD_BEEF;
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    #3;
    chk("t1_wr_wen",  SRAMWEN,   4'hF);
    chk("t1_wr_addr", SRAMADDR,  32'd4);
    chk("t1_wr_cs",   SRAMCS,    1'b1);
    chk("t1_wr_rdy",  HREADYOUT, 1'b1);
    tick();
    idle_ap();
    #3;
    chk("t1_wait_rdy",  HREADYOUT, 1'b0);
    chk("t1_wait_cs",   SRAMCS,    1'b1);
    chk("t1_wait_wen",  SRAMWEN,   4'h0);
    chk("t1_wait_addr", SRAMADDR,  32'd4);
    tick();
    #3;
    chk("t1_rd_rdy",   HREADYOUT, 1'b1);
    chk("t1_rd_data",  HRDATA,    32'hDEAD_BEEF);
    chk("t1_rd_resp",  HRESP,     1'b0);

    // Byte-lane writes over a cleared word.
    tick();
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    tick();
    HWDATA = 32'h0;
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h11);
    #3;
    chk("t2_wen_word", SRAMWEN, 4'hF);
    tick();
    HWDATA = 32'h0000_AA00;
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h13);
    #3;
    chk("t2_wen_b1",  SRAMWEN,  4'b0010);
    chk("t2_addr_b1", SRAMADDR, 32'd4);
    tick();
    HWDATA = 32'h5500_0000;
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    #3;
    chk("t2_wen_b3", SRAMWEN, 4'b1000);
    tick();
    idle_ap();
    #3;
    chk("t2_wait_rdy", HREADYOUT, 1'b0);
    tick();
    #3;
    chk("t2_rd_data", HRDATA, 32'h5500_AA00);

    // Preload four words, then stream four reads at one per cycle.
    for (int i = 0; i < 4; i++) begin
      ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h100 + 32'(4*i));
      if (i > 0) HWDATA = vals[i-1];
      tick();
    end
    HWDATA = vals[3];
    idle_ap();
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) ap(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h100 + 32'(4*i));
      else       idle_ap();
      #3;
      chk("t3_rdy", HREADYOUT, 1'b1);
      if (i > 0) chk("t3_data", HRDATA, vals[i-1]);
      if (i < 4) begin
        chk("t3_cs",   SRAMCS,   1'b1);
        chk("t3_addr", SRAMADDR, 32'h40 + 32'(i));
      end
      tick();
    end

    // Misaligned half read, then an oversized transfer held during the first error.
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h21);
    #3;
    chk("t4_ap_cs",  SRAMCS,    1'b0);
    chk("t4_ap_rdy", HREADYOUT, 1'b1);
    tick();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, 3'd3, 32'h24);
    #3;
    chk("t4_a_err1_rdy",  HREADYOUT, 1'b0);
    chk("t4_a_err1_resp", HRESP,     1'b1);
    chk("t4_a_err1_cs",   SRAMCS,    1'b0);
    tick();
    #3;
    chk("t4_a_err2_rdy",  HREADYOUT, 1'b1);
    chk("t4_a_err2_resp", HRESP,     1'b1);
    chk("t4_a_err2_cs",   SRAMCS,    1'b0);
    tick();
    idle_ap();
    #3;
    chk("t4_b_err1_rdy",  HREADYOUT, 1'b0);
    chk("t4_b_err1_resp", HRESP,     1'b1);
    chk("t4_b_err1_cs",   SRAMCS,    1'b0);
    tick();
    #3;
    chk("t4_b_err2_rdy",  HREADYOUT, 1'b1);
    chk("t4_b_err2_resp", HRESP,     1'b1);
    chk("t4_b_err2_cs",   SRAMCS,    1'b0);
    tick();
    #3;
    chk("t4_done_resp", HRESP,     1'b0);
    chk("t4_done_rdy",  HREADYOUT, 1'b1);
    tick();

    // Non-transfers: deselected, IDLE and BUSY.
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0:       ap(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        1:       ap(1'b1, HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h10);
        default: ap(1'b1, HTRANS_BUSY,   1'b1, HSIZE_WORD, 32'h10);
      endcase
      #3;
      chk("t5_cs_rdy_resp", {SRAMCS, HREADYOUT, HRESP}, 3'b010);
      tick();
    end

    // Reset during a write data phase discards the write.
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40);
    tick();
    HWDATA = 32'h1111_1111;
    idle_ap();
    tick();
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40);
    tick();
    HWDATA = 32'h1234_5678;
    idle_ap();
    #1;
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_cs",   SRAMCS,    1'b0);
    chk("t6_rst_wen",  SRAMWEN,   4'h0);
    chk("t6_rst_rdy",  HREADYOUT, 1'b1);
    chk("t6_rst_resp", HRESP,     1'b0);
    tick();
    #3;
    HRESETn = 1'b1;
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40);
    tick();
    idle_ap();
    #3;
    chk("t6_rd_data", HRDATA, 32'h1111_1111);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
